// File: rtl/divider_radix2.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU: accept in IDLE, 32 CALC steps, then DONE.
// Build option DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'd0
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'd1
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'd2
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'd3
`endif

module divider_radix2 (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              dividend,
    input  logic [31:0]              divisor,
    input  logic [`DIV_OP_WIDTH-1:0] DIVop,
    input  logic                     div_valid,
    output logic                     div_ready,
    output logic [31:0]              div_result,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [63:0]              rq_q, rq_d;
    logic [31:0]              dsor_abs_q, dsor_abs_d;
    logic [31:0]              dvd_q, dvd_d;
    logic [`DIV_OP_WIDTH-1:0] op_q, op_d;
    logic                     neg_quo_q, neg_quo_d;
    logic                     neg_rem_q, neg_rem_d;
    logic                     dz_q, dz_d;
    logic                     ovf_q, ovf_d;
    logic                     ready_q, ready_d;
    logic [31:0]              result_q, result_d;
    logic                     busy_q, busy_d;

    logic        in_signed_s;
    logic        in_dz_s;
    logic        in_ovf_s;
    logic [31:0] dvd_abs_s;
    logic [31:0] dsor_abs_s;
    logic [33:0] diff_s;
    logic [63:0] step_rq_s;
    logic [31:0] final_s;

    // Special cases override the datapath so both builds return identical results.
    function automatic logic [31:0] fix_result(
        input logic [`DIV_OP_WIDTH-1:0] op,
        input logic [63:0]              rq,
        input logic                     neg_quo,
        input logic                     neg_rem,
        input logic                     dz,
        input logic                     ovf,
        input logic [31:0]              dvd
    );
        logic [31:0] quo;
        logic [31:0] rem;
        quo = neg_quo ? (32'd0 - rq[31:0]) : rq[31:0];
        rem = neg_rem ? (32'd0 - rq[63:32]) : rq[63:32];
        if (dz) begin
            quo = 32'hFFFF_FFFF;
            rem = dvd;
        end else if (ovf) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = quo;
            rem = rem;
        end
        if ((op == `DIV_OP_REM) || (op == `DIV_OP_REMU)) begin
            return rem;
        end else begin
            return quo;
        end
    endfunction

    // Operand conditioning at accept time and one restoring step on the live remainder.
    always_comb begin
        in_signed_s = (DIVop == `DIV_OP_DIV) || (DIVop == `DIV_OP_REM);
        in_dz_s     = (divisor == 32'd0);
        in_ovf_s    = in_signed_s && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        dvd_abs_s   = (in_signed_s && dividend[31]) ? (32'd0 - dividend) : dividend;
        dsor_abs_s  = (in_signed_s && divisor[31])  ? (32'd0 - divisor)  : divisor;
        // Shifted partial remainder is 33 bits wide; subtract succeeds when no borrow appears.
        diff_s      = {1'b0, rq_q[63:31]} - {2'b00, dsor_abs_q};
        if (diff_s[33:32] == 2'b00) begin
            step_rq_s = {diff_s[31:0], rq_q[30:0], 1'b1};
        end else begin
            step_rq_s = {rq_q[62:0], 1'b0};
        end
        final_s     = fix_result(op_q, rq_q, neg_quo_q, neg_rem_q, dz_q, ovf_q, dvd_q);
    end

    // Control FSM next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rq_d       = rq_q;
        dsor_abs_d = dsor_abs_q;
        dvd_d      = dvd_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        ready_d    = ready_q;
        result_d   = result_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (div_valid) begin
                    op_d       = DIVop;
                    dvd_d      = dividend;
                    dsor_abs_d = dsor_abs_s;
                    rq_d       = {32'd0, dvd_abs_s};
                    neg_quo_d  = in_signed_s & (dividend[31] ^ divisor[31]);
                    neg_rem_d  = in_signed_s & dividend[31];
                    dz_d       = in_dz_s;
                    ovf_d      = in_ovf_s;
                    cnt_d      = 5'd0;
                    busy_d     = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                    if (in_dz_s || in_ovf_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d    = S_CALC;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rq_d  = step_rq_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            // First DONE cycle registers the corrected result, second presents the strobe.
            S_DONE: begin
                if (!ready_q) begin
                    ready_d  = 1'b1;
                    result_d = final_s;
                    state_d  = S_DONE;
                end else begin
                    ready_d  = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            rq_q       <= 64'd0;
            dsor_abs_q <= 32'd0;
            dvd_q      <= 32'd0;
            op_q       <= {`DIV_OP_WIDTH{1'b0}};
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rq_q       <= rq_d;
            dsor_abs_q <= dsor_abs_d;
            dvd_q      <= dvd_d;
            op_q       <= op_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
        end
    end

    assign div_ready  = ready_q;
    assign div_result = result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_divider_radix2.sv
// Directed self-checking bench for divider_radix2 (latency, special cases, abort, back-to-back).

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'd0
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'd1
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'd2
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'd3
`endif

module tb_divider_radix2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [31:0]              dividend;
    logic [31:0]              divisor;
    logic [`DIV_OP_WIDTH-1:0] DIVop;
    logic                     div_valid;
    logic                     div_ready;
    logic [31:0]              div_result;
    logic                     busy;

    int errors = 0;
    int checks = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    divider_radix2 dut (
        .clk        (clk),
        .reset      (reset),
        .dividend   (dividend),
        .divisor    (divisor),
        .DIVop      (DIVop),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_result (div_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure edges from accept to div_ready, then check strobe drop and hold.
    task automatic run_op(input string tag, input logic [`DIV_OP_WIDTH-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic        busy_ok;
        logic [31:0] res;
        @(negedge clk);
        DIVop     = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        lat       = -1;
        busy_ok   = busy;
        for (int k = 1; (k <= 40) && (lat < 0); k++) begin
            @(posedge clk);
            #1;
            busy_ok = busy_ok & busy;
            if (div_ready) begin
                lat = k;
            end
        end
        res = div_result;
        chk({tag, " result"}, res, exp_res);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " ready_drop"}, {31'd0, div_ready}, 32'd0);
        chk({tag, " busy_drop"}, {31'd0, busy}, 32'd0);
        chk({tag, " result_hold"}, div_result, exp_res);
    endtask

    initial begin
        int          pulses;
        int          cyc;
        int          t1;
        int          t2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        seen_ready;

        reset     = 1'b1;
        div_valid = 1'b0;
        DIVop     = `DIV_OP_DIVU;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {31'd0, div_ready}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst result", div_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("divu_100_7", `DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("rem_m7_2", `DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2", `DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div_100_m7", `DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("rem_100_m7", `DIV_OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
        run_op("div_ovf", `DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        run_op("rem_ovf", `DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT);
        run_op("divu_5_0", `DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("remu_5_0", `DIV_OP_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        run_op("rem_m5_0", `DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT);
        run_op("div_m5_0", `DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);

        // Abort: reset lands in the 10th CALC cycle of DIVU 1000/3.
        @(negedge clk);
        DIVop     = `DIV_OP_DIVU;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ready", {31'd0, div_ready}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort result", div_result, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        seen_ready = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            seen_ready = seen_ready | div_ready;
        end
        chk("abort no_ready", {31'd0, seen_ready}, 32'd0);
        chk("abort idle_busy", {31'd0, busy}, 32'd0);
        run_op("divu_9_3", `DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Back-to-back with div_valid held high; operands switch once the first strobe is seen.
        @(negedge clk);
        DIVop     = `DIV_OP_DIVU;
        dividend  = 32'd20;
        divisor   = 32'd4;
        div_valid = 1'b1;
        pulses    = 0;
        t1        = -1;
        t2        = -1;
        r1        = 32'd0;
        r2        = 32'd0;
        for (cyc = 1; cyc <= 120; cyc++) begin
            @(posedge clk);
            #1;
            if (div_ready) begin
                pulses++;
                if (pulses == 1) begin
                    r1      = div_result;
                    t1      = cyc;
                    DIVop   = `DIV_OP_REMU;
                    divisor = 32'd6;
                end else if (pulses == 2) begin
                    r2        = div_result;
                    t2        = cyc;
                    div_valid = 1'b0;
                end
            end
        end
        chk("b2b pulses", 32'(pulses), 32'd2);
        chk("b2b divu_20_4", r1, 32'd5);
        chk("b2b remu_20_6", r2, 32'd2);
        chk("b2b first_lat", 32'(t1), 32'd34);
        chk("b2b gap", 32'(t2 - t1), 32'd35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider_radix2.md
DIVIDER_RADIX2 -- requirements
Module: divider_radix2

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: dividend  input  32  rs1 operand.
REQ-004 SHALL have port: divisor  input  32  rs2 operand.
REQ-005 SHALL have port: DIVop  input  `DIV_OP_WIDTH  operation, encoded with `DIV_OP_DIV/DIVU/REM/REMU from riscv_defines.vh.
REQ-006 SHALL have port: div_valid  input  1  request, driven by the divider decoder's div_valid; held high by the control FSM until div_ready.
REQ-007 SHALL have port: div_ready  output  1  one-cycle completion strobe.
REQ-008 SHALL have port: div_result  output  32  quotient or remainder, per DIVop.
REQ-009 SHALL have port: busy  output  1  high from the accept edge until div_ready is deasserted.

Function
REQ-010 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-011 SHALL, in IDLE with div_valid=1, accept the request on that edge: latch operands, DIVop, |dividend|, |divisor| (signed ops only), quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]); go to CALC.
REQ-012 SHALL, in CALC, perform one restoring-division step per cycle (shift 64-bit remainder:quotient, trial-subtract, set quotient bit), counted by a 5-bit iteration counter, for exactly 32 cycles, then go to DONE.
REQ-013 SHALL, in DONE, drive div_ready=1 for exactly one cycle with div_result valid, then return to IDLE.
REQ-014 SHALL give a fixed latency: request accepted at edge N -> div_ready high in the cycle following edge N+33.
REQ-015 SHALL apply sign correction: negate the quotient if the quotient sign is set (DIV); negate the remainder if the remainder sign is set (REM); DIVU/REMU are uncorrected.
REQ-016 SHALL, for divisor=0, return 0xFFFFFFFF for DIV/DIVU and the original dividend for REM/REMU.
REQ-017 SHALL, for DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-018 SHALL ignore div_valid while in CALC or DONE; a request held high through DONE is re-accepted only from IDLE, on the cycle after div_ready.
REQ-019 SHALL hold div_result stable from DONE until the next accept edge.

Reset
REQ-020 SHALL, on reset=1 at a rising edge, enter IDLE and clear div_ready=0, busy=0, div_result=0, and the iteration counter.
REQ-021 SHALL give reset priority over div_valid and abort any in-flight operation; no div_ready SHALL follow an aborted operation.

Configuration
REQ-022 SHALL honour the macro DIV_FAST_SPECIAL_EN.
- Defined: divide-by-zero and signed-overflow cases (REQ-016/017) skip CALC and go IDLE -> DONE; div_ready is high in the cycle after the accept edge.
- Undefined: all operations take the full REQ-014 latency.
- Results SHALL be identical in both builds.

Verification
REQ-023 SHALL cover: DIVU 100/7 -> div_result=14, div_ready at accept+33 cycles, busy high throughout.
REQ-024 SHALL cover: REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF; DIV of same operands -> 0xFFFFFFFD (-3).
REQ-025 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; latency 1 with DIV_FAST_SPECIAL_EN defined, 33 without.
REQ-026 SHALL cover: reset asserted on the 10th CALC cycle -> div_ready never pulses, all outputs 0; a following DIVU 9/3 -> 3.
REQ-027 SHALL cover: div_valid held high for two back-to-back ops (DIVU 20/4, then REMU 20/6) -> exactly one div_ready per op, results 5 and 2, and div_valid during CALC causes no re-accept.
